// File: rtl/sub_serial.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin, DIGIT bits per clock, LS slice first.
// Optional macro SUB_SERIAL_SAT_EN saturates diff on signed overflow.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one slice per cycle, NDIG cycles
// DONE  | result and flags held until out_ready
module sub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] diff_raw, diff_fin;
  logic             ovf_raw;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;

    // Operands shift right each slice, so the current slice is always the low DIGIT bits.
    sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, ~b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, ~borrow_q};
    diff_raw = diff_q >> DIGIT;
    diff_raw[WIDTH-1 -: DIGIT] = sum[DIGIT-1:0];
    ovf_raw  = (a_msb_q != b_msb_q) && (diff_raw[WIDTH-1] != a_msb_q);
    diff_fin = diff_raw;
`ifdef SUB_SERIAL_SAT_EN
    if (ovf_raw) diff_fin = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          borrow_d = bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        borrow_d = ~sum[DIGIT];
        idx_d    = idx_q + 1'b1;
        diff_d   = diff_raw;
        if (idx_q == LAST) begin
          diff_d  = diff_fin;
          bout_d  = ~sum[DIGIT];
          zero_d  = (diff_fin == '0);
          neg_d   = diff_fin[WIDTH-1];
          ovf_d   = ovf_raw;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial: driver pushes expected results, negedge monitor pops and compares.
module tb_sub_serial;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, bin, out_valid, out_ready;
  logic         bout, zero, neg, ovf;
  logic [W-1:0] a, b, diff;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         n;
    logic         o;
  } res_t;

  res_t exp_q[$];
  int   lat_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   acc_v;
  res_t e_v;
  logic ov_prev = 1'b0;

  sub_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  function automatic res_t mk(input logic [W-1:0] d, input logic bo, input logic z,
                              input logic n, input logic o);
    res_t r;
    r.d = d; r.bo = bo; r.z = z; r.n = n; r.o = o;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (lat_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          acc_v = lat_q.pop_front();
          check("latency", 32'(cyc - acc_v), 32'd4);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else begin
          e_v = exp_q.pop_front();
          check("diff", 32'(diff), 32'(e_v.d));
          check("flags{bout,zero,neg,ovf}", 32'({bout, zero, neg, ovf}),
                32'({e_v.bo, e_v.z, e_v.n, e_v.o}));
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input res_t e);
    int n;
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    lat_q.push_back(cyc);
    exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({bout, zero, neg, ovf}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(16'h1234, 16'h0234, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b0, 1'b0)); drain();
    send(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0)); drain();
`ifdef SUB_SERIAL_SAT_EN
    send(16'h8000, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b0, 1'b1, 1'b1)); drain();
`else
    send(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1)); drain();
`endif
    send(16'h5555, 16'h5554, 1'b1, mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0)); drain();
    send(16'h0000, 16'hFFFF, 1'b1, mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0)); drain();

    // Backpressure: result held in DONE while operands and in_valid churn.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0F00, 1'b0, mk(16'hF1FF, 1'b1, 1'b0, 1'b1, 1'b0));
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      a = 16'h1111 * 16'(i + 1); b = 16'h0101 * 16'(i + 2); bin = i[0]; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_hold_diff", 32'(diff), 32'h0000F1FF);
      check("bp_hold_flags", 32'({bout, zero, neg, ovf}), 32'b1010);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    a = 16'h7FFF; b = 16'hFFFF; bin = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_accepted", 32'(in_ready), 32'd0);
    lat_q.push_back(cyc);
`ifdef SUB_SERIAL_SAT_EN
    exp_q.push_back(mk(16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1));
`else
    exp_q.push_back(mk(16'h8000, 1'b1, 1'b0, 1'b1, 1'b1));
`endif
    in_valid = 1'b0;
    drain();

    // Reset pulse in the second RUN cycle discards the transaction.
    a = 16'h1111; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_run_state", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_release_out_valid", 32'(out_valid), 32'd0);
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    send(16'h0010, 16'h0001, 1'b0, mk(16'h000F, 1'b0, 1'b0, 1'b0, 1'b0)); drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Multi-cycle, digit-serial two's-complement subtractor for the ALU datapath: computes diff = a - b - bin.
- Processes one DIGIT-bit slice per clock, least-significant slice first, with a registered borrow chained between slices.
- Uses a valid/ready handshake on both the operand side and the result side.
- Reports ALU status flags: borrow-out, zero, negative, signed overflow.
- Serves as the subtract-direction counterpart to the team's lookahead adder blocks, for area-constrained datapaths.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per cycle.
- NDIG (derived, localparam), WIDTH/DIGIT, number of RUN cycles.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a, b, bin are valid.
- in_ready  out  1  block can accept operands; equals (state==IDLE).
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH (see Optional Feature).
- bout  out  1  final borrow; 1 iff unsigned a < b + bin.
- zero  out  1  diff == 0.
- neg  out  1  diff[WIDTH-1].
- ovf  out  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset (asynchronous, any time): state=IDLE, digit index=0, borrow=0, diff=0, all flags=0, out_valid=0. in_ready=1 while in IDLE.
- State machine IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid is 1 at a clock edge: latch a, b; load borrow with bin; set index=0; go to RUN.
  - If in_valid=0, stay in IDLE.
- RUN (exactly NDIG cycles, in_ready=0):
  - Each cycle, for slice i = index: {c, d} = a_i + ~b_i + ~borrow (DIGIT+1-bit sum).
  - diff slice i <= d; borrow <= ~c; index increments.
  - After the slice with index = NDIG-1: compute flags from the full latched operands and final diff; go to DONE.
- DONE:
  - out_valid=1; diff and all flags are stable and held while out_ready=0.
  - When out_ready=1 at an edge: go to IDLE; out_valid falls on that edge.
- Latency: if the operand handshake completes at edge E, out_valid is 1 from edge E+NDIG (E+4 for default parameters).
- Throughput: one result per NDIG+2 cycles, with out_ready held high.
- in_ready=0 in both RUN and DONE. in_valid asserted there is ignored; the source must hold its operands until in_ready returns to 1.
- Changes on a, b, bin during RUN do not affect the result, because operands are latched.
- Flag rules:
  - zero and neg are derived from the final diff (after saturation, if enabled).
  - bout is always the raw unsigned borrow out of the MSB slice.
  - ovf is always the raw signed-overflow condition.
- Reset during RUN or DONE: the transaction is discarded, out_valid=0 immediately, and no partial result is emitted.
- diff/flag registers are not cleared on return to IDLE. Their values are don't-care while out_valid=0.

Optional Feature:
- Macro: SUB_SERIAL_SAT_EN.
- Defined: on signed overflow (ovf=1), diff is replaced in DONE with the saturated value.
  - 0x7FFF when a[MSB]=0.
  - 0x8000 when a[MSB]=1.
  - The WIDTH-generic equivalents apply.
  - Saturation is applied in the same edge that enters DONE, so latency is unchanged.
- Undefined: diff wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan:
- a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, zero=0, neg=0, ovf=0; out_valid rises exactly 4 edges after accept.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, neg=1, zero=0, ovf=0 (borrow ripples through all 4 slices).
- a=0x8000, b=0x0001, bin=0 -> ovf=1, bout=0.
  - Without the macro: diff=0x7FFF, neg=0.
  - With SUB_SERIAL_SAT_EN: diff=0x8000, neg=1.
- a=0x5555, b=0x5554, bin=1 -> diff=0x0000, zero=1, bout=0, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE, toggle a/b and hold in_valid=1 -> diff/flags unchanged and in_ready=0 throughout. After out_ready=1, the new operands are accepted on the first IDLE cycle and produce a correct result.
- Assert rst for 1 cycle during the 2nd RUN cycle -> out_valid=0 and in_ready=1 after release. A following transaction a=0x0010, b=0x0001 gives diff=0x000F with correct 4-cycle latency.
